// File: rtl/irq_priority_encoder.sv
// Six-source interrupt priority encoder: captures edge/level requests, masks them,
// and presents the lowest-index eligible source to the CPU with an ack/eret handshake.
module irq_priority_encoder #(
    parameter logic [5:0] EdgeMask = 6'b000000
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic [5:0] Req_In,
    input  logic [5:0] Int_Enable,
    input  logic       Global_En,
    input  logic       Ack,
    input  logic       Eret,
    input  logic       Ovf_Clr,
    output logic       Irq_Out,
    output logic [2:0] Irq_Id,
    output logic       Busy,
    output logic [5:0] Pending,
    output logic [5:0] Overrun
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] req_q;
    logic [5:0] pend_q, pend_d;
    logic [5:0] ovf_q, ovf_d;
    logic [2:0] id_q, id_d;
    logic [5:0] edge_det;
    logic [5:0] ack_clr;
    logic [5:0] eff;
    logic [5:0] id_oh;
    logic       ack_hit;

    // Lowest set index wins; an all-zero vector yields 0 but is never used that way.
    function automatic logic [2:0] lowest_index(input logic [5:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (v[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    assign id_oh   = 6'b000001 << id_q;
    assign ack_hit = (state_q == S_REQ) && Ack;

    // Pending/overrun next state; a new edge beats an Ack clear and an Ovf_Clr.
    always_comb begin
        edge_det = Req_In & ~req_q & EdgeMask;
        if (ack_hit) begin
            ack_clr = id_oh & EdgeMask;
        end else begin
            ack_clr = 6'b000000;
        end
        pend_d = (((pend_q & ~ack_clr) | edge_det) & EdgeMask) | (Req_In & ~EdgeMask);
        if (Ovf_Clr) begin
            ovf_d = 6'b000000;
        end else begin
            ovf_d = ovf_q;
        end
        ovf_d = ovf_d | (edge_det & pend_q & ~ack_clr);
        eff   = pend_q & Int_Enable & {6{Global_En}};
    end

    // Handshake FSM; Irq_Id is only reloaded when leaving IDLE.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        case (state_q)
            S_IDLE: begin
                if (eff != 6'b000000) begin
                    state_d = S_REQ;
                    id_d    = lowest_index(eff);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (Ack) begin
                    state_d = S_SERVICE;
                end else if ((eff & id_oh) == 6'b000000) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_SERVICE: begin
                if (Eret) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_SERVICE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            req_q   <= 6'b000000;
            pend_q  <= 6'b000000;
            ovf_q   <= 6'b000000;
            id_q    <= 3'd0;
        end else begin
            state_q <= state_d;
            req_q   <= Req_In;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            id_q    <= id_d;
        end
    end

    assign Irq_Out = (state_q == S_REQ);
    assign Busy    = (state_q == S_SERVICE);
    assign Irq_Id  = id_q;
    assign Pending = pend_q;
    assign Overrun = ovf_q;

endmodule
